// File: rtl/fir_tap_window_if.sv
// Stream bundle for fir_tap_window: sample input, flush, and the presented tap window.
// master drives samples/flush/win_ready; slave (the window writer) drives the rest.
interface fir_tap_window_if #(
    parameter int ORDER  = 4,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(ORDER + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    flush;
    logic                    win_valid;
    logic                    win_ready;
    logic [ORDER*DATA_W-1:0] win_data;
    logic [CNT_W-1:0]        fill_count;

    modport master (
        output in_valid, in_data, flush, win_ready,
        input  in_ready, win_valid, win_data, fill_count
    );

    modport slave (
        input  in_valid, in_data, flush, win_ready,
        output in_ready, win_valid, win_data, fill_count
    );
endinterface

// File: rtl/fir_tap_window.sv
// ORDER-deep sample delay line presented as a tap window over valid/ready.
// Optional macro FIR_WIN_ZERO_FILL_EN: present windows from the first sample (zero-filled taps).
module fir_tap_window #(
    parameter int ORDER  = 4,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    fir_tap_window_if.slave  bus,
    output logic             dbg_state_o
);
    // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge.
    // valid never depends on ready; in_ready never depends on in_valid.
    localparam int CNT_W = $clog2(ORDER + 1);
    localparam int WIN_W = ORDER * DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(ORDER);
    localparam logic [CNT_W-1:0] WARM = CNT_W'(ORDER - 1);

    typedef enum logic {
        EMPTY   = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] fill_q;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic             present_on_accept;

    assign in_ready = !rst && !bus.flush && (state_q == EMPTY || bus.win_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = (state_q == PRESENT) && bus.win_ready;

`ifdef FIR_WIN_ZERO_FILL_EN
    assign present_on_accept = 1'b1;
`else
    // Warm-up samples shift in silently until the window is full.
    assign present_on_accept = (fill_q >= WARM);
`endif

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q <= EMPTY;
            win_q   <= '0;
            fill_q  <= '0;
        end else begin
            if (accept) begin
                win_q <= {win_q[WIN_W-DATA_W-1:0], bus.in_data};
                if (fill_q != FULL) begin
                    fill_q <= fill_q + CNT_W'(1);
                end
            end
            case (state_q)
                EMPTY: begin
                    if (accept && present_on_accept) begin
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (consume && !accept) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.win_valid  = (state_q == PRESENT);
    assign bus.win_data   = win_q;
    assign bus.fill_count = fill_q;
    assign dbg_state_o    = (state_q == PRESENT);
endmodule
